// File: rtl/l0_loader_if.sv
// rtl/l0_loader_if.sv - SRAM read port and L0 write port bundle for l0_loader
interface l0_loader_if #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
);
  logic                  sram_cen;
  logic                  sram_wen;
  logic [addr_w-1:0]     sram_addr;
  logic [row*bw-1:0]     sram_dout;
  logic                  l0_wr;
  logic [row*bw-1:0]     l0_data;
  logic                  l0_ready;

  modport master (
    output sram_cen, sram_wen, sram_addr, l0_wr, l0_data,
    input  sram_dout, l0_ready
  );

  modport slave (
    input  sram_cen, sram_wen, sram_addr, l0_wr, l0_data,
    output sram_dout, l0_ready
  );
endinterface

// File: rtl/l0_loader.sv
// rtl/l0_loader.sv - SRAM-to-L0 word loader with credit-limited reads and a 2-entry skid buffer
// Optional L0_LOADER_STALL_CNT_EN adds a 16-bit saturating L0 back-pressure cycle counter.
module l0_loader #(
  parameter int row    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [addr_w:0]   num_words,
  output logic              busy,
  output logic              done,
`ifdef L0_LOADER_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  l0_loader_if.master       mem
);
  localparam int dw = row * bw;
  localparam logic [addr_w:0] one_w = 1;
  localparam logic [addr_w-1:0] one_a = 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [addr_w:0]   total, issued, written;
  logic [addr_w-1:0] rd_addr;
  logic [1:0]        credits;
  logic              pend;
  logic [dw-1:0]     skid0, skid1;
  logic [1:0]        occ;
  logic              accept, wr, issue, last_issue, last_wr;

  // A credit returned by this cycle's L0 write is reusable at once, which keeps one word per cycle.
  assign accept     = (state == IDLE) && start;
  assign wr         = (occ != 2'd0) && mem.l0_ready;
  assign issue      = (state == FETCH) && ((credits != 2'd0) || wr);
  assign last_issue = issue && (issued == total - one_w);
  assign last_wr    = wr && (written == total - one_w);

  assign mem.sram_cen  = ~issue;
  assign mem.sram_wen  = 1'b1;
  assign mem.sram_addr = rd_addr;
  assign mem.l0_wr     = wr;
  assign mem.l0_data   = skid0;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (num_words == '0) ? DONE : FETCH;
      FETCH: begin
        busy = 1'b1;
        if (last_issue) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_wr) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      total   <= '0;
      issued  <= '0;
      written <= '0;
      rd_addr <= '0;
      credits <= 2'd2;
      pend    <= 1'b0;
      occ     <= 2'd0;
      skid0   <= '0;
      skid1   <= '0;
    end else begin
      state   <= state_nx;
      pend    <= issue;
      credits <= credits - {1'b0, issue} + {1'b0, wr};
      if (accept) begin
        total   <= num_words;
        issued  <= '0;
        written <= '0;
        if (num_words != '0) rd_addr <= base_addr;
      end else begin
        if (issue) issued <= issued + one_w;
        if (wr) written <= written + one_w;
      end
      // rd_addr stays on the final address once the last read has gone out
      if (issue && !last_issue) rd_addr <= rd_addr + one_a;
      case ({pend, wr})
        2'b10: begin
          if (occ == 2'd0) skid0 <= mem.sram_dout;
          else             skid1 <= mem.sram_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) skid0 <= mem.sram_dout;
          else begin
            skid0 <= skid1;
            skid1 <= mem.sram_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef L0_LOADER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept)
      stall_cnt <= '0;
    else if ((state == FETCH || state == DRAIN) && (occ != 2'd0) && !mem.l0_ready
             && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_l0_loader.sv
// tb/tb_l0_loader.sv - self-checking bench for l0_loader against an SRAM image and word-order model
module tb_l0_loader;
  localparam int ROW = 8, BW = 4, AW = 11, DW = ROW * BW, DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done;
`ifdef L0_LOADER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  l0_loader_if #(.row(ROW), .bw(BW), .addr_w(AW)) mem ();

  l0_loader #(.row(ROW), .bw(BW), .addr_w(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
`ifdef L0_LOADER_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .mem       (mem)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) if (!mem.sram_cen) mem.sram_dout <= sram[mem.sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  int            wr_cyc_q[$];
  int            done_q[$];
  int            outst = 0, max_out = 0;

  always @(negedge clk) begin
    if (!mem.sram_cen) begin
      rd_q.push_back(mem.sram_addr);
      outst = outst + 1;
    end
    if (mem.l0_wr) begin
      wr_q.push_back(mem.l0_data);
      wr_cyc_q.push_back(cyc);
      outst = outst - 1;
    end
    if (outst > max_out) max_out = outst;
    if (done) done_q.push_back(cyc);
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int base; int num; int stall_at; int stall_len; int restart_at;
    int exp_done; int exp_first; int exp_stall; bit rnd;
  } vec_t;

  task automatic run_load(input vec_t v);
    int rd0, wr0, dc0, t0, i, nr, nw;
    bit seen;
    @(posedge clk); #1;
    rd0 = rd_q.size(); wr0 = wr_q.size(); dc0 = done_q.size();
    outst = 0; max_out = 0;
    t0 = cyc;
    start = 1'b1; base_addr = AW'(v.base); num_words = (AW+1)'(v.num);
    mem.l0_ready = 1'b1;
    seen = 1'b0;
    for (i = 1; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      start = (i == v.restart_at);
      if (i == v.restart_at) begin
        base_addr = AW'(12'h555); num_words = (AW+1)'(3);
      end
      if (v.rnd) mem.l0_ready = ($urandom_range(0, 9) < 7);
      else mem.l0_ready = !(v.stall_len > 0 && i >= v.stall_at && i < v.stall_at + v.stall_len);
      if (i == 1) begin
        chk("busy_after_start", busy, v.num > 0);
        chk("done_after_start", done, v.num == 0);
      end
      seen = (done_q.size() > dc0);
    end
    start = 1'b0;
    mem.l0_ready = 1'b1;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within 400 cycles (base %0h num %0d)", v.base, v.num);
    end
    @(posedge clk); #1;
    nr = rd_q.size() - rd0;
    nw = wr_q.size() - wr0;
    chk("read_count", nr, v.num);
    chk("write_count", nw, v.num);
    chk("done_count", done_q.size() - dc0, 1);
    chk("max_outstanding_le2", max_out <= 2, 1);
    chk("busy_idle", busy, 0);
    for (int k = 0; k < v.num && k < nr; k++)
      chk("sram_addr", rd_q[rd0+k], (v.base + k) % DEPTH);
    for (int k = 0; k < v.num && k < nw; k++)
      chk("l0_data", wr_q[wr0+k], sram[(v.base + k) % DEPTH]);
    if (seen && v.num > 0 && nw > 0)
      chk("done_after_last_wr", done_q[dc0] - wr_cyc_q[wr0+nw-1], 1);
    if (seen && v.exp_done >= 0) chk("done_latency", done_q[dc0] - t0, v.exp_done);
    if (v.exp_first >= 0 && nw > 0) chk("first_wr_latency", wr_cyc_q[wr0] - t0, v.exp_first);
`ifdef L0_LOADER_STALL_CNT_EN
    if (v.exp_stall >= 0) chk("stall_cnt", stall_cnt, v.exp_stall);
`endif
  endtask

  vec_t vecs[8];
  vec_t rv;
  int wr0, dc0, k;

  initial begin
    for (int a = 0; a < DEPTH; a++) sram[a] = $urandom;
    vecs[0] = '{'h010, 4,  0, 0, 0, 7,  3, 0, 0};
    vecs[1] = '{'h7FE, 4,  0, 0, 0, 7,  3, 0, 0};
    vecs[2] = '{'h000, 16, 6, 5, 0, 24, 3, 5, 0};
    vecs[3] = '{'h123, 0,  0, 0, 0, 1, -1, 0, 0};
    vecs[4] = '{'h3FF, 1,  0, 0, 0, 4,  3, 0, 0};
    vecs[5] = '{'h7FF, 2,  3, 2, 0, 7,  5, 2, 0};
    vecs[6] = '{'h040, 6,  0, 0, 3, 9,  3, 0, 0};
    vecs[7] = '{'h200, 3,  5, 3, 0, 9,  3, 3, 0};

    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; mem.l0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cen", mem.sram_cen, 1);
    chk("rst_wen", mem.sram_wen, 1);
    chk("rst_addr", mem.sram_addr, 0);
    chk("rst_l0_wr", mem.l0_wr, 0);

    for (int v = 0; v < 8; v++) run_load(vecs[v]);

    // abort a load of 8 after three words have reached L0
    @(posedge clk); #1;
    wr0 = wr_q.size();
    start = 1'b1; base_addr = AW'(12'h100); num_words = (AW+1)'(8);
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (wr_q.size() - wr0 < 3 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("abort_reach_3_writes", wr_q.size() - wr0 >= 3, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wr0 = wr_q.size(); dc0 = done_q.size();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cen", mem.sram_cen, 1);
    chk("abort_addr", mem.sram_addr, 0);
    chk("abort_l0_wr", mem.l0_wr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_writes", wr_q.size() - wr0, 0);
    chk("abort_no_done", done_q.size() - dc0, 0);
    rv = '{'h055, 2, 0, 0, 0, 5, 3, 0, 0};
    run_load(rv);

    for (int r = 0; r < 20; r++) begin
      rv = '{0, 0, 0, 0, 0, -1, -1, -1, 1};
      rv.base = $urandom_range(0, DEPTH - 1);
      rv.num  = $urandom_range(1, 24);
      if (r % 5 == 0) rv.restart_at = $urandom_range(1, 6);
      run_load(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
